hashtable_mp: RTL and testbench
===============================

HASHTABLE_MP -- requirements
Module: hashtable_mp

Interface
REQ-001 SHALL have parameter NPORTS, default 4, number of lookup ports (even, 2..8).
REQ-002 SHALL have parameter NBITS, default 15, hash address width.
REQ-003 SHALL have parameter DWIDTH, default 16, output data width (>= NBITS).
REQ-004 SHALL have parameter WORD_W, default 8, bitmap word width (power of 2, 8..64).
REQ-005 SHALL have parameter INIT_FILE, default "./hashtable1.mif", bitmap initial contents.
REQ-006 SHALL have parameter CNT_W, default 32, hit-counter width.
REQ-007 SHALL have port clk  input  1  sole clock, all logic on rising edge.
REQ-008 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-009 SHALL have port addr  input  NPORTS*NBITS  lookup hash per port, port i at [i*NBITS +: NBITS].
REQ-010 SHALL have port addr_valid  input  NPORTS  lookup qualifier per port.
REQ-011 SHALL have port dout  output  NPORTS*DWIDTH  matched hash per port, zero-extended.
REQ-012 SHALL have port dout_valid  output  NPORTS  high only for a valid lookup that hit.
REQ-013 SHALL have port wr_en  input  1  bitmap word write strobe.
REQ-014 SHALL have port wr_addr  input  NBITS-log2(WORD_W)  bitmap word address.
REQ-015 SHALL have port wr_data  input  WORD_W  new bitmap word.
REQ-016 SHALL have port cnt_clr  input  1  synchronous clear of all hit counters.
REQ-017 SHALL have port hit_cnt  output  NPORTS*CNT_W  per-port hit count.

Function
REQ-018 SHALL split each addr into word address addr[NBITS-1:log2(WORD_W)] and bit index addr[log2(WORD_W)-1:0].
REQ-019 SHALL have fixed latency 3: lookup presented at cycle t produces dout/dout_valid at t+3, every port independent, one lookup per port per cycle, no stalls.
REQ-020 SHALL drive dout_valid[i] = addr_valid[i] (delayed) AND bit (bit index) of the addressed word; dout[i] = delayed addr[i] regardless of hit.
REQ-021 SHALL apply a write at cycle w to every bitmap replica; lookups presented at t > w see new data, lookups presented at t <= w see old data, including lookups already in the pipeline to the same word.
REQ-022 SHALL guarantee REQ-021 independent of RAM read-during-write mode via address compare/bypass in the pipeline.
REQ-023 SHALL accept wr_en every cycle; back-to-back writes to the same word: last write wins.
REQ-024 SHALL increment hit_cnt[i] by 1 in the cycle dout_valid[i] is asserted; saturate at 2^CNT_W-1, no wrap.
REQ-025 SHALL give cnt_clr priority over a coincident increment (counter becomes 0 that cycle).
REQ-026 SHALL not change bitmap contents except via wr_en.

Reset
REQ-027 SHALL on rst_n low asynchronously clear dout, dout_valid, hit_cnt and all pipeline valids to 0.
REQ-028 SHALL not reset bitmap contents; INIT_FILE image persists across reset, prior writes retained.
REQ-029 SHALL ignore wr_en, addr_valid and cnt_clr while rst_n is low; lookups in flight at reset are discarded, no dout_valid after release for them.
REQ-030 SHALL produce first possible dout_valid 3 cycles after the first valid lookup following reset release.

Structure
REQ-031 SHALL place default parameters, log2(WORD_W) and counter width constants in shared package hashtable_pkg.
REQ-032 SHALL use one sub-module bitmap_ram_2r1w (two read ports, one write port, INIT_FILE), instantiated NPORTS/2 times as replicas sharing the write port.

Verification
REQ-033 SHALL verify: INIT_FILE word 0x005 = 0x10, addr0=0x002C valid at t -> dout0=0x002C, dout_valid0=1 at t+3; addr0=0x002D -> dout_valid0=0.
REQ-034 SHALL verify: all 4 ports valid same cycle with hashes hitting/missing mixed -> each port's dout_valid matches its own bitmap bit, no cross-talk.
REQ-035 SHALL verify: lookup 0x0048 at t=5, wr_en wr_addr=0x009 wr_data=0x01 at t=6 and lookup 0x0048 at t=7 -> first uses old word (miss), second hits.
REQ-036 SHALL verify: counter preloaded near saturation (CNT_W=4 build) with 20 hits -> hit_cnt holds 15; cnt_clr with coincident hit -> 0.
REQ-037 SHALL verify: rst_n asserted with 3 lookups in flight -> no dout_valid after release, hit_cnt=0, previously written word still returns its written value.

Source files
------------

// File: rtl/hashtable_pkg.sv
// Shared defaults and width helpers for the multi-port hash bitmap lookup.
package hashtable_pkg;

  localparam int unsigned NPORTS_DEF    = 4;
  localparam int unsigned NBITS_DEF     = 15;
  localparam int unsigned DWIDTH_DEF    = 16;
  localparam int unsigned WORD_W_DEF    = 8;
  localparam int unsigned CNT_W_DEF     = 32;
  localparam string       INIT_FILE_DEF = "./hashtable1.mif";

  // Number of hash bits that select a bit inside one bitmap word.
  function automatic int unsigned bit_idx_w(input int unsigned word_w);
    return $clog2(word_w);
  endfunction

  localparam int unsigned BIT_IDX_W_DEF = bit_idx_w(WORD_W_DEF);

endpackage

// File: rtl/hashtable_mp_bitmap_ram.sv
// Bitmap replica: one synchronous write port, two registered read ports.
module bitmap_ram_2r1w
  import hashtable_pkg::*;
#(
  parameter int unsigned AW        = NBITS_DEF - BIT_IDX_W_DEF,
  parameter int unsigned WORD_W    = WORD_W_DEF,
  parameter string       INIT_FILE = INIT_FILE_DEF
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [WORD_W-1:0] wdata,
  input  logic [AW-1:0]     raddr_a,
  input  logic [AW-1:0]     raddr_b,
  output logic [WORD_W-1:0] rdata_a,
  output logic [WORD_W-1:0] rdata_b
);

  localparam int unsigned DEPTH = 1 << AW;

  // Storage is never reset; a preload image is attached only when one is named.
  if (INIT_FILE != "") begin : g_store
    (* ram_init_file = INIT_FILE *) logic [WORD_W-1:0] mem [DEPTH];

    // Write port and both registered read ports.
    always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
      rdata_a <= mem[raddr_a];
      rdata_b <= mem[raddr_b];
    end
  end else begin : g_store
    logic [WORD_W-1:0] mem [DEPTH];

    // Write port and both registered read ports.
    always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
      rdata_a <= mem[raddr_a];
      rdata_b <= mem[raddr_b];
    end
  end

endmodule

// File: rtl/hashtable_mp.sv
// Multi-port hash bitmap lookup: 3-cycle pipeline per port, shared write port,
// per-port saturating hit counters.
module hashtable_mp
  import hashtable_pkg::*;
#(
  parameter int unsigned NPORTS    = NPORTS_DEF,
  parameter int unsigned NBITS     = NBITS_DEF,
  parameter int unsigned DWIDTH    = DWIDTH_DEF,
  parameter int unsigned WORD_W    = WORD_W_DEF,
  parameter string       INIT_FILE = INIT_FILE_DEF,
  parameter int unsigned CNT_W     = CNT_W_DEF
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic [NPORTS*NBITS-1:0]              addr,
  input  logic [NPORTS-1:0]                    addr_valid,
  output logic [NPORTS*DWIDTH-1:0]             dout,
  output logic [NPORTS-1:0]                    dout_valid,
  input  logic                                 wr_en,
  input  logic [NBITS-bit_idx_w(WORD_W)-1:0]   wr_addr,
  input  logic [WORD_W-1:0]                    wr_data,
  input  logic                                 cnt_clr,
  output logic [NPORTS*CNT_W-1:0]              hit_cnt
);

  localparam int unsigned IDX_W = bit_idx_w(WORD_W);
  localparam int unsigned WA_W  = NBITS - IDX_W;
  localparam int unsigned NREP  = NPORTS / 2;

  // Writes are committed one cycle late so a lookup issued in the write cycle
  // reads the old word without relying on the RAM read-during-write mode.
  logic              wq_en;
  logic [WA_W-1:0]   wq_addr;
  logic [WORD_W-1:0] wq_data;
  logic [WORD_W-1:0] byp_data;

  logic [WA_W-1:0]   rd_addr [NPORTS];
  logic [WORD_W-1:0] rd_word [NPORTS];

  // Pending-write register and the copy of the word committed at each edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wq_en    <= 1'b0;
      wq_addr  <= '0;
      wq_data  <= '0;
      byp_data <= '0;
    end else begin
      wq_en    <= wr_en;
      wq_addr  <= wr_addr;
      wq_data  <= wr_data;
      byp_data <= wq_data;
    end
  end

  for (genvar i = 0; i < NPORTS; i++) begin : g_raddr
    assign rd_addr[i] = addr[i*NBITS + IDX_W +: WA_W];
  end

  for (genvar r = 0; r < NREP; r++) begin : g_rep
    bitmap_ram_2r1w #(
      .AW        (WA_W),
      .WORD_W    (WORD_W),
      .INIT_FILE (INIT_FILE)
    ) u_ram (
      .clk     (clk),
      .we      (wq_en),
      .waddr   (wq_addr),
      .wdata   (wq_data),
      .raddr_a (rd_addr[2*r]),
      .raddr_b (rd_addr[2*r+1]),
      .rdata_a (rd_word[2*r]),
      .rdata_b (rd_word[2*r+1])
    );
  end

  for (genvar i = 0; i < NPORTS; i++) begin : g_port
    logic              s1_vld;
    logic              s1_byp;
    logic [NBITS-1:0]  s1_addr;
    logic              s2_hit;
    logic [NBITS-1:0]  s2_addr;
    logic              dv;
    logic [DWIDTH-1:0] dq;
    logic [CNT_W-1:0]  cnt;
    logic [WORD_W-1:0] word_c;

    // A write committing on the same edge as this port's read overrides the RAM data.
    assign word_c = s1_byp ? byp_data : rd_word[i];

    // Lookup pipeline: capture, bit select, output; counter tracks output hits.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        s1_vld  <= 1'b0;
        s1_byp  <= 1'b0;
        s1_addr <= '0;
        s2_hit  <= 1'b0;
        s2_addr <= '0;
        dv      <= 1'b0;
        dq      <= '0;
        cnt     <= '0;
      end else begin
        s1_vld  <= addr_valid[i];
        s1_byp  <= wq_en && (wq_addr == rd_addr[i]);
        s1_addr <= addr[i*NBITS +: NBITS];
        s2_hit  <= s1_vld && word_c[s1_addr[IDX_W-1:0]];
        s2_addr <= s1_addr;
        dv      <= s2_hit;
        dq      <= DWIDTH'(s2_addr);
        if (cnt_clr) begin
          cnt <= '0;
        end else if (s2_hit && (cnt != '1)) begin
          cnt <= cnt + CNT_W'(1);
        end
      end
    end

    assign dout_valid[i]                = dv;
    assign dout[i*DWIDTH +: DWIDTH]     = dq;
    assign hit_cnt[i*CNT_W +: CNT_W]    = cnt;
  end

endmodule

// File: tb/tb_hashtable_mp.sv
// Directed bench for hashtable_mp: streamed vector table plus reset/counter sequences.
module tb_hashtable_mp;

  localparam int unsigned NP = 4;
  localparam int unsigned NB = 15;
  localparam int unsigned DW = 16;
  localparam int unsigned WW = 8;
  localparam int unsigned CW = 4;
  localparam int unsigned WA = 12;
  localparam int NV = 16;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NP*NB-1:0]  addr;
  logic [NP-1:0]     addr_valid;
  logic [NP*DW-1:0]  dout;
  logic [NP-1:0]     dout_valid;
  logic              wr_en;
  logic [WA-1:0]     wr_addr;
  logic [WW-1:0]     wr_data;
  logic              cnt_clr;
  logic [NP*CW-1:0]  hit_cnt;

  hashtable_mp #(
    .NPORTS (NP),
    .NBITS  (NB),
    .DWIDTH (DW),
    .WORD_W (WW),
    .CNT_W  (CW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .addr       (addr),
    .addr_valid (addr_valid),
    .dout       (dout),
    .dout_valid (dout_valid),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .cnt_clr    (cnt_clr),
    .hit_cnt    (hit_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0][14:0] a;
    logic [3:0]       v;
    logic             we;
    logic [11:0]      wa;
    logic [7:0]       wd;
    logic [3:0]       edv;
  } vec_t;

  vec_t tbl [NV];
  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    addr       = '0;
    addr_valid = '0;
    wr_en      = 1'b0;
    wr_addr    = '0;
    wr_data    = '0;
    cnt_clr    = 1'b0;
  endtask

  function automatic vec_t mk(input logic [14:0] a0, input logic [14:0] a1,
                              input logic [14:0] a2, input logic [14:0] a3,
                              input logic [3:0] v, input logic we,
                              input logic [11:0] wa, input logic [7:0] wd,
                              input logic [3:0] edv);
    vec_t r;
    r.a   = {a3, a2, a1, a0};
    r.v   = v;
    r.we  = we;
    r.wa  = wa;
    r.wd  = wd;
    r.edv = edv;
    return r;
  endfunction

  function automatic logic [63:0] exp_dout(input logic [3:0][14:0] a);
    logic [63:0] e;
    for (int i = 0; i < 4; i++) e[i*16 +: 16] = {1'b0, a[i]};
    return e;
  endfunction

  function automatic logic [7:0] init_word(input int w);
    case (w)
      'h000:   return 8'h01;
      'h005:   return 8'h10;
      'h123:   return 8'hA5;
      'hFFF:   return 8'h80;
      default: return 8'h00;
    endcase
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: bench did not reach its end");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [3:0] acc;

    // Lookup stream; words 0x000/0x005/0x123/0xFFF preloaded, 0x009..0x00B start at 0.
    tbl[0]  = mk(15'h002C, 15'h002D, 15'h0918, 15'h0919, 4'b1111, 1'b0, 12'h000, 8'h00, 4'b0101);
    tbl[1]  = mk(15'h0001, 15'h0000, 15'h7FF8, 15'h7FFF, 4'b1111, 1'b0, 12'h000, 8'h00, 4'b1010);
    tbl[2]  = mk(15'h002C, 15'h0918, 15'h091A, 15'h7FFF, 4'b0101, 1'b0, 12'h000, 8'h00, 4'b0101);
    tbl[3]  = mk(15'h091F, 15'h091E, 15'h091A, 15'h002C, 4'b1111, 1'b0, 12'h000, 8'h00, 4'b1101);
    tbl[4]  = mk(15'h002C, 15'h0918, 15'h7FFF, 15'h0000, 4'b0000, 1'b0, 12'h000, 8'h00, 4'b0000);
    tbl[5]  = mk(15'h002C, 15'h002C, 15'h002C, 15'h002C, 4'b1111, 1'b0, 12'h000, 8'h00, 4'b1111);
    tbl[6]  = mk(15'h0048, 15'h0000, 15'h0000, 15'h0000, 4'b0001, 1'b0, 12'h000, 8'h00, 4'b0000);
    tbl[7]  = mk(15'h0000, 15'h0000, 15'h0000, 15'h0000, 4'b0000, 1'b1, 12'h009, 8'h01, 4'b0000);
    tbl[8]  = mk(15'h0048, 15'h0000, 15'h0000, 15'h0000, 4'b0001, 1'b0, 12'h000, 8'h00, 4'b0001);
    tbl[9]  = mk(15'h0050, 15'h0000, 15'h0000, 15'h0000, 4'b0001, 1'b1, 12'h00A, 8'h01, 4'b0000);
    tbl[10] = mk(15'h0050, 15'h0050, 15'h0000, 15'h0000, 4'b0011, 1'b0, 12'h000, 8'h00, 4'b0011);
    tbl[11] = mk(15'h0000, 15'h0000, 15'h0058, 15'h0000, 4'b0100, 1'b1, 12'h00B, 8'h01, 4'b0000);
    tbl[12] = mk(15'h0000, 15'h0000, 15'h0058, 15'h0000, 4'b0100, 1'b1, 12'h00B, 8'h00, 4'b0100);
    tbl[13] = mk(15'h0000, 15'h0000, 15'h0058, 15'h0058, 4'b1100, 1'b0, 12'h000, 8'h00, 4'b0000);
    tbl[14] = mk(15'h0000, 15'h0000, 15'h0000, 15'h0058, 4'b1000, 1'b0, 12'h000, 8'h00, 4'b0000);
    tbl[15] = mk(15'h0048, 15'h0048, 15'h0048, 15'h0048, 4'b1111, 1'b0, 12'h000, 8'h00, 4'b1111);

    // Reset state
    rst_n = 1'b0;
    idle();
    repeat (2) @(posedge clk);
    #1;
    chk("reset dout_valid", 64'(dout_valid), 64'h0);
    chk("reset dout", dout, 64'h0);
    chk("reset hit_cnt", 64'(hit_cnt), 64'h0);
    rst_n = 1'b1;
    step();

    // Load the whole bitmap through the write port
    for (int w = 0; w < 4096; w++) begin
      wr_en   = 1'b1;
      wr_addr = WA'(w);
      wr_data = init_word(w);
      step();
    end
    idle();
    step();
    step();

    // Streamed table: row k presented in cycle k, its result checked three cycles later
    for (int k = 0; k < NV + 2; k++) begin
      if (k < NV) begin
        addr       = tbl[k].a;
        addr_valid = tbl[k].v;
        wr_en      = tbl[k].we;
        wr_addr    = tbl[k].wa;
        wr_data    = tbl[k].wd;
      end else begin
        idle();
      end
      step();
      if (k >= 2) begin
        chk($sformatf("row%0d dout_valid", k - 2), 64'(dout_valid), 64'(tbl[k-2].edv));
        chk($sformatf("row%0d dout", k - 2), dout, exp_dout(tbl[k-2].a));
      end
    end
    chk("stream hit_cnt", 64'(hit_cnt), 64'h4647);

    // Saturation: clear, then 20 hits on every port
    cnt_clr = 1'b1;
    step();
    cnt_clr = 1'b0;
    chk("clear hit_cnt", 64'(hit_cnt), 64'h0);
    for (int n = 0; n < 20; n++) begin
      addr       = {4{15'h002C}};
      addr_valid = 4'b1111;
      step();
    end
    idle();
    repeat (3) step();
    chk("saturated hit_cnt", 64'(hit_cnt), 64'hFFFF);

    cnt_clr = 1'b1;
    step();
    cnt_clr = 1'b0;
    chk("clear from saturation", 64'(hit_cnt), 64'h0);

    // Clear coincident with the increment edge of a port-0 hit
    addr       = {45'h0, 15'h002C};
    addr_valid = 4'b0001;
    step();
    idle();
    step();
    cnt_clr = 1'b1;
    step();
    cnt_clr = 1'b0;
    chk("clr+hit dout_valid", 64'(dout_valid), 64'h1);
    chk("clr+hit hit_cnt", 64'(hit_cnt), 64'h0);

    addr       = {45'h0, 15'h002C};
    addr_valid = 4'b0001;
    step();
    idle();
    step();
    step();
    chk("count resumes", 64'(hit_cnt), 64'h1);

    // Reset with lookups in flight; write, clear and lookups during reset are ignored
    for (int n = 0; n < 3; n++) begin
      addr       = {4{15'h002C}};
      addr_valid = 4'b1111;
      step();
    end
    rst_n = 1'b0;
    addr_valid = 4'b1111;
    wr_en      = 1'b1;
    wr_addr    = 12'h005;
    wr_data    = 8'h00;
    cnt_clr    = 1'b1;
    #1;
    chk("async reset dout_valid", 64'(dout_valid), 64'h0);
    chk("async reset dout", dout, 64'h0);
    chk("async reset hit_cnt", 64'(hit_cnt), 64'h0);
    repeat (3) step();
    rst_n = 1'b1;
    idle();
    acc = '0;
    for (int n = 0; n < 6; n++) begin
      step();
      acc |= dout_valid;
    end
    chk("post-reset dout_valid", 64'(acc), 64'h0);
    chk("post-reset hit_cnt", 64'(hit_cnt), 64'h0);

    // First lookup after reset: nothing early, both retained words hit at +3
    addr       = {15'h0, 15'h0, 15'h0918, 15'h002C};
    addr_valid = 4'b0011;
    step();
    idle();
    step();
    chk("first lookup not early", 64'(dout_valid), 64'h0);
    step();
    chk("first lookup dout_valid", 64'(dout_valid), 64'h3);
    chk("first lookup dout", dout, 64'h0000_0000_0918_002C);
    chk("first lookup hit_cnt", 64'(hit_cnt), 64'h0011);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
